// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register of the five-stage MIPS core. Captures
//             register-file read data, decoded control and the sign-extended
//             immediate of the ID instruction, detects load-use hazards
//             against the instruction in EX (one bubble, PC and IF/ID frozen),
//             honours branch flush and downstream hold, and keeps a
//             saturating count of load-use bubbles.
//  Ports    : clock, reset_n (async, active-low)
//             id_*   : ID-stage instruction, operands and decoded control
//             flush  : squash ID (taken branch/jump resolved in EX)
//             hold   : downstream stall, freeze the whole front end
//             stall  : freeze PC and IF/ID this cycle
//             ex_*   : registered EX-stage instruction state
//             stall_count : saturating count of load-use bubbles
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc4,
  input  logic [31:0]      id_rdata1,
  input  logic [31:0]      id_rdata2,
  input  logic             id_uses_rt,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_MemtoReg,
  input  logic             id_ALUSrc,
  input  logic             id_RegDst,
  input  logic [3:0]       id_ALUOp,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic             ex_valid,
  output logic [31:0]      ex_pc4,
  output logic [31:0]      ex_a,
  output logic [31:0]      ex_b,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_wreg,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_MemtoReg,
  output logic             ex_ALUSrc,
  output logic             ex_RegDst,
  output logic [3:0]       ex_ALUOp,
  output logic [CNT_W-1:0] stall_count
);

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        hz;
  logic        load_slot;
  logic        capture;
  logic        count_en;
  logic        unused_opcode;

  assign rs  = id_instr[25:21];
  assign rt  = id_instr[20:16];
  assign rd  = id_instr[15:11];
  assign imm = id_instr[15:0];

  // The opcode is decoded upstream; only the register and immediate fields
  // are consumed here.
  assign unused_opcode = ^id_instr[31:26];

  // Load in EX whose destination is a source of the ID instruction. $0 is
  // hard-wired to zero, so a load targeting it never creates a dependency.
  assign hz = ex_valid & ex_MemRead & (ex_rt != 5'd0) & id_valid &
              ((ex_rt == rs) | (id_uses_rt & (ex_rt == rt)));

  // A flush squashes ID anyway, so there is nothing to freeze for it.
  assign stall = !flush & (hold | hz);

  // The EX slot is rewritten on every edge except a hold; whether it receives
  // the ID instruction or a bubble is decided by capture.
  assign load_slot = flush | !hold;
  assign capture   = !flush & !hold & !hz & id_valid;
  assign count_en  = !flush & !hold & hz & ~&stall_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_pc4      <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_wreg     <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_ALUOp    <= '0;
      stall_count <= '0;
    end else begin
      if (load_slot) begin
        // A bubble clears data fields as well as control so that an idle
        // EX slot always looks identical regardless of history.
        ex_valid    <= capture;
        ex_pc4      <= capture ? id_pc4 : 32'd0;
        ex_a        <= capture ? id_rdata1 : 32'd0;
        ex_b        <= capture ? id_rdata2 : 32'd0;
        ex_imm      <= capture ? {{16{imm[15]}}, imm} : 32'd0;
        ex_rs       <= capture ? rs : 5'd0;
        ex_rt       <= capture ? rt : 5'd0;
        ex_wreg     <= capture ? (id_RegDst ? rd : rt) : 5'd0;
        ex_RegWrite <= capture & id_RegWrite;
        ex_MemRead  <= capture & id_MemRead;
        ex_MemWrite <= capture & id_MemWrite;
        ex_MemtoReg <= capture & id_MemtoReg;
        ex_ALUSrc   <= capture & id_ALUSrc;
        ex_RegDst   <= capture & id_RegDst;
        ex_ALUOp    <= capture ? id_ALUOp : 4'd0;
      end
      if (count_en) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Purpose  : Directed self-checking bench for id_ex_stage. A second instance
//             with a 4-bit counter shares all inputs to exercise saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_instr, id_pc4, id_rdata1, id_rdata2;
  logic        id_uses_rt;
  logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst;
  logic [3:0]  id_ALUOp;
  logic        flush, hold;

  logic        stall, ex_valid;
  logic [31:0] ex_pc4, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst;
  logic [3:0]  ex_ALUOp;
  logic [15:0] stall_count;

  logic        s_stall, s_ex_valid;
  logic [31:0] s_ex_pc4, s_ex_a, s_ex_b, s_ex_imm;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_wreg;
  logic        s_ex_RegWrite, s_ex_MemRead, s_ex_MemWrite, s_ex_MemtoReg, s_ex_ALUSrc, s_ex_RegDst;
  logic [3:0]  s_ex_ALUOp;
  logic [3:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  id_ex_stage #(.CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_uses_rt(id_uses_rt),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
    .id_ALUOp(id_ALUOp), .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
    .ex_pc4(ex_pc4), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc(ex_ALUSrc),
    .ex_RegDst(ex_RegDst), .ex_ALUOp(ex_ALUOp), .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(4)) dut_small (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_uses_rt(id_uses_rt),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
    .id_ALUOp(id_ALUOp), .flush(flush), .hold(hold), .stall(s_stall), .ex_valid(s_ex_valid),
    .ex_pc4(s_ex_pc4), .ex_a(s_ex_a), .ex_b(s_ex_b), .ex_imm(s_ex_imm), .ex_rs(s_ex_rs),
    .ex_rt(s_ex_rt), .ex_wreg(s_ex_wreg), .ex_RegWrite(s_ex_RegWrite), .ex_MemRead(s_ex_MemRead),
    .ex_MemWrite(s_ex_MemWrite), .ex_MemtoReg(s_ex_MemtoReg), .ex_ALUSrc(s_ex_ALUSrc),
    .ex_RegDst(s_ex_RegDst), .ex_ALUOp(s_ex_ALUOp), .stall_count(s_stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_instr = 0; id_pc4 = 0; id_rdata1 = 0; id_rdata2 = 0; id_uses_rt = 0;
    id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0; id_MemtoReg = 0; id_ALUSrc = 0;
    id_RegDst = 0; id_ALUOp = 0;
  endtask

  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic uses_rt, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] pc4);
    id_valid = 1; id_instr = {6'h00, rs, rt, rd, 5'd0, 6'h20}; id_pc4 = pc4;
    id_rdata1 = r1; id_rdata2 = r2; id_uses_rt = uses_rt;
    id_RegWrite = 1; id_MemRead = 0; id_MemWrite = 0; id_MemtoReg = 0; id_ALUSrc = 0;
    id_RegDst = 1; id_ALUOp = 4'h2;
  endtask

  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    id_valid = 1; id_instr = {6'h23, rs, rt, imm}; id_pc4 = 32'h200;
    id_rdata1 = 32'h100; id_rdata2 = 32'h55; id_uses_rt = 0;
    id_RegWrite = 1; id_MemRead = 1; id_MemWrite = 0; id_MemtoReg = 1; id_ALUSrc = 1;
    id_RegDst = 0; id_ALUOp = 4'h0;
  endtask

  initial begin
    reset_n = 0; flush = 0; hold = 0;
    drive_idle();
    step(); step();
    reset_n = 1;
    #1;
    check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_count", {16'd0, stall_count}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);

    // Plain capture
    drive_add(5'd3, 5'd4, 5'd5, 1'b1, 32'h11, 32'h22, 32'h104);
    #1 check("cap_stall", {31'd0, stall}, 32'd0);
    step();
    check("cap_valid", {31'd0, ex_valid}, 32'd1);
    check("cap_a", ex_a, 32'h11);
    check("cap_b", ex_b, 32'h22);
    check("cap_wreg", {27'd0, ex_wreg}, 32'd5);
    check("cap_rs_rt", {22'd0, ex_rs, ex_rt}, {22'd0, 5'd3, 5'd4});
    check("cap_pc4", ex_pc4, 32'h104);
    check("cap_imm", ex_imm, 32'h0000_2820);
    check("cap_ctrl", {26'd0, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst},
          32'b100001);
    check("cap_aluop", {28'd0, ex_ALUOp}, 32'h2);

    // Load-use via rs
    drive_lw(5'd2, 5'd8, 16'hFFFC);
    step();
    check("lw_ctrl", {26'd0, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst},
          32'b110110);
    check("lw_wreg", {27'd0, ex_wreg}, 32'd8);
    check("lw_imm_sext", ex_imm, 32'hFFFF_FFFC);
    drive_add(5'd8, 5'd9, 5'd10, 1'b1, 32'h33, 32'h44, 32'h10C);
    #1 check("lu_stall", {31'd0, stall}, 32'd1);
    step();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_ctrl", {26'd0, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst},
          32'd0);
    check("lu_bubble_data", ex_a | ex_b | ex_pc4 | ex_imm, 32'd0);
    check("lu_bubble_idx", {17'd0, ex_rs, ex_rt, ex_wreg}, 32'd0);
    check("lu_count", {16'd0, stall_count}, 32'd1);
    check("lu_stall_after", {31'd0, stall}, 32'd0);
    step();
    check("lu_capture_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_capture_wreg", {27'd0, ex_wreg}, 32'd10);
    check("lu_capture_a", ex_a, 32'h33);

    // rt dependency ignored when rt is not a source, honoured when it is
    drive_lw(5'd2, 5'd8, 16'h0004);
    step();
    drive_add(5'd9, 5'd8, 5'd11, 1'b0, 32'h1, 32'h2, 32'h110);
    #1 check("rt_unused_stall", {31'd0, stall}, 32'd0);
    step();
    check("rt_unused_capture", {27'd0, ex_wreg}, 32'd11);
    check("rt_unused_count", {16'd0, stall_count}, 32'd1);
    drive_lw(5'd2, 5'd8, 16'h0004);
    step();
    drive_add(5'd9, 5'd8, 5'd12, 1'b1, 32'h1, 32'h2, 32'h114);
    #1 check("rt_used_stall", {31'd0, stall}, 32'd1);
    step();
    check("rt_used_bubble", {31'd0, ex_valid}, 32'd0);
    check("rt_used_count", {16'd0, stall_count}, 32'd2);
    step();

    // Register 0
    drive_lw(5'd2, 5'd0, 16'h0004);
    step();
    drive_add(5'd0, 5'd0, 5'd13, 1'b1, 32'h0, 32'h0, 32'h118);
    #1 check("zero_stall", {31'd0, stall}, 32'd0);
    step();
    check("zero_capture", {27'd0, ex_wreg}, 32'd13);
    check("zero_count", {16'd0, stall_count}, 32'd2);

    // Flush beats hazard
    drive_lw(5'd2, 5'd8, 16'h0004);
    step();
    drive_add(5'd8, 5'd8, 5'd14, 1'b1, 32'h5, 32'h6, 32'h11C);
    flush = 1;
    #1 check("flush_stall", {31'd0, stall}, 32'd0);
    step();
    flush = 0;
    check("flush_bubble", {31'd0, ex_valid}, 32'd0);
    check("flush_memread", {31'd0, ex_MemRead}, 32'd0);
    check("flush_count", {16'd0, stall_count}, 32'd2);

    // Hold without hazard: EX keeps the captured add, then new data captured
    drive_add(5'd1, 5'd2, 5'd20, 1'b1, 32'hA0, 32'hB0, 32'h120);
    step();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive_add(5'd3, 5'd4, 5'd21, 1'b1, 32'hC0 + i, 32'hD0, 32'h124);
      #1 check("hold_stall", {31'd0, stall}, 32'd1);
      step();
      check("hold_wreg", {27'd0, ex_wreg}, 32'd20);
      check("hold_a", ex_a, 32'hA0);
    end
    check("hold_count", {16'd0, stall_count}, 32'd2);
    hold = 0;
    #1 check("hold_release_stall", {31'd0, stall}, 32'd0);
    step();
    check("hold_release_wreg", {27'd0, ex_wreg}, 32'd21);
    check("hold_release_a", ex_a, 32'hC2);

    // Hold together with hazard: load stays, then hazard handled after hold
    drive_lw(5'd2, 5'd8, 16'h0004);
    step();
    drive_add(5'd8, 5'd0, 5'd22, 1'b0, 32'h7, 32'h8, 32'h128);
    hold = 1;
    #1 check("hold_hz_stall", {31'd0, stall}, 32'd1);
    step();
    check("hold_hz_keep", {31'd0, ex_MemRead}, 32'd1);
    check("hold_hz_count", {16'd0, stall_count}, 32'd2);
    hold = 0;
    #1 check("hold_hz_restall", {31'd0, stall}, 32'd1);
    step();
    check("hold_hz_bubble", {31'd0, ex_valid}, 32'd0);
    check("hold_hz_count2", {16'd0, stall_count}, 32'd3);
    step();
    check("hold_hz_capture", {27'd0, ex_wreg}, 32'd22);

    // Asynchronous reset mid-cycle while EX is valid
    #3;
    reset_n = 0;
    #1;
    check("areset_valid", {31'd0, ex_valid}, 32'd0);
    check("areset_wreg", {27'd0, ex_wreg}, 32'd0);
    check("areset_a", ex_a, 32'd0);
    check("areset_count", {16'd0, stall_count}, 32'd0);
    check("areset_stall", {31'd0, stall}, 32'd0);
    step();
    reset_n = 1;

    // Saturation: 17 load-use bubbles
    for (int i = 0; i < 17; i++) begin
      drive_lw(5'd2, 5'd8, 16'h0004);
      step();
      drive_add(5'd8, 5'd1, 5'd3, 1'b1, 32'h1, 32'h2, 32'h130);
      step();
      if (i == 14) check("sat_small_15", {28'd0, s_stall_count}, 32'hF);
    end
    check("sat_small_17", {28'd0, s_stall_count}, 32'hF);
    check("sat_wide_17", {16'd0, stall_count}, 32'd17);

    drive_idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the five-stage MIPS core. It captures the register-file read data for the instruction in ID, plus decoded control and immediate fields, into the ID/EX pipeline register. It detects load-use hazards against the instruction currently in EX and inserts one bubble while freezing PC and IF/ID. It also handles branch flush and downstream hold, and keeps a saturating count of hazard stalls.

## Interface
Parameters:
- CNT_W, 16, width of the hazard-stall counter

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID slot holds a real instruction
- id_instr  in  32  instruction in ID; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]
- id_pc4  in  32  PC+4 of the ID instruction
- id_rdata1  in  32  register-file read data for rs
- id_rdata2  in  32  register-file read data for rt
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst  in  1 each  decoded control
- id_ALUOp  in  4  decoded ALU operation
- flush  in  1  branch/jump resolved taken in EX; squash ID
- hold  in  1  downstream stall; freeze whole front end
- stall  out  1  freeze PC and IF/ID this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc4, ex_a, ex_b, ex_imm  out  32 each  captured PC+4, rs data, rt data, sign-extended immediate
- ex_rs, ex_rt, ex_wreg  out  5 each  source indices and destination register
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst  out  1 each  registered control
- ex_ALUOp  out  4  registered ALU operation
- stall_count  out  CNT_W  number of load-use bubbles inserted, saturating

## Operation
- Hazard (combinational): hz = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == rs) | (id_uses_rt & (ex_rt == rt))).
- stall = !flush & (hold | hz). This signal is combinational from the current ex_* registers and the id_* inputs.
- Per-edge action, first match wins:
  - flush: load a bubble.
  - hold: all ex_* outputs keep their values.
  - hz: load a bubble and increment stall_count.
  - otherwise: capture the ID instruction, or a bubble if !id_valid.
- Bubble: ex_valid and all ex_* control bits set to 0. ex_pc4, ex_a, ex_b, ex_imm, ex_rs, ex_rt and ex_wreg are also cleared to 0.
- Capture:
  - ex_a = id_rdata1, ex_b = id_rdata2.
  - ex_imm = {{16{imm[15]}}, imm}.
  - ex_wreg = id_RegDst ? rd : rt.
  - Control bits are copied unchanged.
- Register 0 never causes a hazard.
- The register file writes on the falling clock edge. A WB write in cycle N is therefore visible on id_rdata1/2 before the rising edge that ends cycle N, so this block has no WB-to-ID bypass.
- stall_count saturates at all-ones. It does not increment on hold or flush cycles.

## Timing
- Latency is one cycle from ID inputs to ex_* outputs.
- Reset value of every output register is 0: ex_valid=0, all control 0, all data 0, stall_count=0.
- stall follows the same reset: with ex_valid=0 there is no hazard, so stall depends only on hold/flush.
- Load-use costs exactly one bubble. In the cycle after the bubble, ex_MemRead=0, hz deasserts, and the dependent instruction is captured.
- flush together with hz: flush wins, stall=0, and stall_count does not increment.
- hold together with hz: hold wins, the EX slot keeps the load, and stall stays 1. The hazard is re-evaluated after hold drops.
- Reset asserted mid-stall: outputs clear immediately (asynchronously). stall drops once hold is low.

## Test plan
- Reset: drive reset_n=0 mid-run with ex_valid=1 -> all ex_* outputs and stall_count read 0 before the next edge; stall=0 with hold=0.
- Plain capture: id_valid=1, add with rs=3, rt=4, rd=5, id_RegDst=1, id_rdata1=0x11, id_rdata2=0x22 -> one edge later ex_a=0x11, ex_b=0x22, ex_wreg=5, ex_valid=1.
- Load-use: lw $8 in EX (ex_rt=8, ex_MemRead=1), then add using rs=8 in ID ->
  - stall=1 for one cycle and a bubble is loaded; stall_count=1.
  - Next edge: the add is captured.
  - A dependent instruction using only rt=8 with id_uses_rt=0 causes no stall.
- Zero register and flush priority:
  - lw $0 followed by a use of $0 -> no stall.
  - flush=1 together with a load-use hazard -> bubble, stall=0, stall_count unchanged.
- Hold: hold=1 for 3 cycles with new ID data -> ex_* unchanged and stall=1 throughout; stall_count unchanged; capture on the first edge after hold=0.
- Saturation: CNT_W=4, force 17 load-use bubbles -> stall_count stops at 0xF.
